// File: rtl/clock_divider_multi.sv
// Multi-channel programmable clock divider. Each channel produces a square wave and a
// one-cycle wrap strobe, and runs free or advances one period per step request.
module clock_divider_multi #(
  parameter int CHANNELS        = 2,
  parameter int WIDTH           = 28,
  parameter int DEFAULT_DIVISOR = 10_000_000,
  parameter int CHAN_BITS       = 1
) (
  input  logic                 clock_in,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic [CHAN_BITS-1:0] wr_chan,
  input  logic [WIDTH-1:0]     wr_divisor,
  input  logic [CHANNELS-1:0]  enable,
  input  logic [CHANNELS-1:0]  mode_step,
  input  logic [CHANNELS-1:0]  step_req,
  output logic [CHANNELS-1:0]  clock_out,
  output logic [CHANNELS-1:0]  tick_out,
  output logic [CHANNELS-1:0]  busy
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] DIV_RESET = WIDTH'(DEFAULT_DIVISOR);
  localparam logic [WIDTH-1:0] DIV_MIN   = WIDTH'(2);
  localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

  // Divisors below 2 cannot produce a low and a high phase, so they are clamped.
  logic [WIDTH-1:0] wr_value;
  assign wr_value = (wr_divisor < DIV_MIN) ? DIV_MIN : wr_divisor;

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_chan
    state_t           state, state_nxt;
    logic [WIDTH-1:0] cnt, cnt_nxt;
    logic [WIDTH-1:0] div, div_nxt;
    logic [WIDTH-1:0] pend, pend_nxt;
    logic             pend_v, pend_v_nxt;
    logic             write_hit, advancing, at_last, wrap;
    logic [WIDTH-1:0] eff_pend;
    logic             eff_v;

    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
      write_hit  = wr_en && (32'(wr_chan) == ch);
      advancing  = enable[ch] && (state == RUN);
      at_last    = (cnt == div - ONE);
      wrap       = advancing && at_last;
      // A write in the wrap cycle counts as already pending, so it lands at that wrap.
      eff_pend   = write_hit ? wr_value : pend;
      eff_v      = write_hit || pend_v;

      state_nxt  = state;
      cnt_nxt    = cnt;
      div_nxt    = div;
      pend_nxt   = eff_pend;
      pend_v_nxt = eff_v;

      if (!advancing || at_last) cnt_nxt = '0;
      else                       cnt_nxt = cnt + ONE;

      // Divisor swaps only at a period boundary or while the counter is parked at 0.
      if ((wrap || !advancing) && eff_v) begin
        div_nxt    = eff_pend;
        pend_v_nxt = 1'b0;
      end

      unique case (state)
        IDLE:    if (!mode_step[ch] || (enable[ch] && step_req[ch])) state_nxt = RUN;
        RUN:     if (wrap && mode_step[ch]) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    // NOTE: every register, pending divisor included, is reset so a reset discards queued writes.
    always_ff @(posedge clock_in) begin
      if (reset) begin
        state  <= mode_step[ch] ? IDLE : RUN;
        cnt    <= '0;
        div    <= DIV_RESET;
        pend   <= '0;
        pend_v <= 1'b0;
      end else begin
        state  <= state_nxt;
        cnt    <= cnt_nxt;
        div    <= div_nxt;
        pend   <= pend_nxt;
        pend_v <= pend_v_nxt;
      end
    end

    // Square wave comes straight from registers; odd divisors get the longer high phase.
    assign clock_out[ch] = (cnt >= (div >> 1));
    assign tick_out[ch]  = wrap;
    assign busy[ch]      = (state == RUN) && mode_step[ch];
  end

endmodule

// File: tb/tb_clock_divider_multi.sv
// Directed bench for clock_divider_multi with small divisors so whole periods are cheap
// to step through; every expected pattern below is written out by hand.
module tb_clock_divider_multi;

  localparam int CHANNELS        = 2;
  localparam int WIDTH           = 8;
  localparam int DEFAULT_DIVISOR = 4;
  localparam int CHAN_BITS       = 2;

  logic                 clock_in = 1'b0;
  logic                 reset;
  logic                 wr_en;
  logic [CHAN_BITS-1:0] wr_chan;
  logic [WIDTH-1:0]     wr_divisor;
  logic [CHANNELS-1:0]  enable;
  logic [CHANNELS-1:0]  mode_step;
  logic [CHANNELS-1:0]  step_req;
  logic [CHANNELS-1:0]  clock_out;
  logic [CHANNELS-1:0]  tick_out;
  logic [CHANNELS-1:0]  busy;

  int tests_run    = 0;
  int tests_failed = 0;

  clock_divider_multi #(
    .CHANNELS       (CHANNELS),
    .WIDTH          (WIDTH),
    .DEFAULT_DIVISOR(DEFAULT_DIVISOR),
    .CHAN_BITS      (CHAN_BITS)
  ) dut (
    .clock_in  (clock_in),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_chan   (wr_chan),
    .wr_divisor(wr_divisor),
    .enable    (enable),
    .mode_step (mode_step),
    .step_req  (step_req),
    .clock_out (clock_out),
    .tick_out  (tick_out),
    .busy      (busy)
  );

  always #5 clock_in = ~clock_in;

  // Inputs change and outputs are sampled on the falling edge, away from the active edge.
  task automatic test_reset();
    logic [7:0] ec = 8'b00110011;
    logic [7:0] et = 8'b00010001;
    reset = 1'b1; wr_en = 1'b0; wr_chan = '0; wr_divisor = '0;
    enable = 2'b11; mode_step = 2'b00; step_req = 2'b00;
    repeat (2) @(negedge clock_in);
    tests_run++;
    if ({clock_out, tick_out, busy} !== 6'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %b, expected 000000", {clock_out, tick_out, busy});
    end
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tests_run++;
      if (clock_out !== {2{ec[7-i]}} || tick_out !== {2{et[7-i]}}) begin
        tests_failed++;
        $display("FAIL free_run_div4[%0d]: clock_out=%b tick_out=%b, expected %b %b",
                 i, clock_out, tick_out, {2{ec[7-i]}}, {2{et[7-i]}});
      end
      @(negedge clock_in);
    end
  endtask

  // ch0 gets divisor 5 at cnt=1; its current period still ends at cnt=3.
  task automatic test_write_midperiod();
    logic [11:0] c0 = 12'b110011100111;
    logic [11:0] t0 = 12'b010000100001;
    logic [11:0] c1 = 12'b110011001100;
    logic [11:0] t1 = 12'b010001000100;
    @(negedge clock_in);
    wr_en = 1'b1; wr_chan = 2'd0; wr_divisor = 8'd5;
    @(negedge clock_in);
    wr_en = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tests_run++;
      if (clock_out !== {c1[11-i], c0[11-i]} || tick_out !== {t1[11-i], t0[11-i]}) begin
        tests_failed++;
        $display("FAIL write_midperiod[%0d]: clock_out=%b tick_out=%b, expected %b %b",
                 i, clock_out, tick_out, {c1[11-i], c0[11-i]}, {t1[11-i], t0[11-i]});
      end
      @(negedge clock_in);
    end
  endtask

  // Out-of-range channel writes must not reach ch1; then a clamped divisor of 2 does.
  task automatic test_out_of_range();
    logic [9:0] c0 = 10'b0011100111;
    logic [9:0] t0 = 10'b0000100001;
    logic [9:0] c1 = 10'b1100110101;
    logic [9:0] t1 = 10'b0100010101;
    for (int i = 0; i < 10; i++) begin
      tests_run++;
      if (clock_out !== {c1[9-i], c0[9-i]} || tick_out !== {t1[9-i], t0[9-i]}) begin
        tests_failed++;
        $display("FAIL out_of_range[%0d]: clock_out=%b tick_out=%b, expected %b %b",
                 i, clock_out, tick_out, {c1[9-i], c0[9-i]}, {t1[9-i], t0[9-i]});
      end
      case (i)
        0: begin wr_en = 1'b1; wr_chan = 2'd3; wr_divisor = 8'd0;   end
        1: begin wr_en = 1'b1; wr_chan = 2'd3; wr_divisor = 8'd1;   end
        2: begin wr_en = 1'b1; wr_chan = 2'd3; wr_divisor = 8'd200; end
        3: begin wr_en = 1'b1; wr_chan = 2'd1; wr_divisor = 8'd1;   end
        default: wr_en = 1'b0;
      endcase
      @(negedge clock_in);
    end
  endtask

  // ch0 switches to step mode with divisor 6; one step request gives exactly one period.
  task automatic test_step();
    logic [9:0] c0 = 10'b0001110000;
    logic [9:0] t0 = 10'b0000010000;
    logic [9:0] b0 = 10'b1111110000;
    mode_step[0] = 1'b1;
    wr_en = 1'b1; wr_chan = 2'd0; wr_divisor = 8'd6;
    @(negedge clock_in);
    wr_en = 1'b0;
    repeat (7) @(negedge clock_in);
    tests_run++;
    if (busy !== 2'b00 || clock_out[0] !== 1'b0 || tick_out[0] !== 1'b0) begin
      tests_failed++;
      $display("FAIL step_idle: busy=%b clock_out[0]=%b tick_out[0]=%b, expected 00 0 0",
               busy, clock_out[0], tick_out[0]);
    end
    step_req[0] = 1'b1;
    @(negedge clock_in);
    step_req[0] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tests_run++;
      if (clock_out[0] !== c0[9-i] || tick_out[0] !== t0[9-i] || busy !== {1'b0, b0[9-i]}) begin
        tests_failed++;
        $display("FAIL step_period[%0d]: clock_out[0]=%b tick_out[0]=%b busy=%b, expected %b %b %b",
                 i, clock_out[0], tick_out[0], busy, c0[9-i], t0[9-i], {1'b0, b0[9-i]});
      end
      if (i == 2) step_req[0] = 1'b1;
      if (i == 3) step_req[0] = 1'b0;
      @(negedge clock_in);
    end
  endtask

  // ch0 back to free-run, divisor 3 written then enable dropped at cnt=2.
  task automatic test_disable();
    logic [5:0] c0 = 6'b110110;
    logic [5:0] t0 = 6'b010010;
    mode_step[0] = 1'b0;
    @(negedge clock_in);
    @(negedge clock_in);
    wr_en = 1'b1; wr_chan = 2'd0; wr_divisor = 8'd3;
    @(negedge clock_in);
    wr_en = 1'b0;
    enable[0] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock_in);
      tests_run++;
      if (clock_out[0] !== 1'b0 || tick_out[0] !== 1'b0) begin
        tests_failed++;
        $display("FAIL disabled[%0d]: clock_out[0]=%b tick_out[0]=%b, expected 0 0",
                 i, clock_out[0], tick_out[0]);
      end
    end
    enable[0] = 1'b1;
    @(negedge clock_in);
    for (int i = 0; i < 6; i++) begin
      tests_run++;
      if (clock_out[0] !== c0[5-i] || tick_out[0] !== t0[5-i]) begin
        tests_failed++;
        $display("FAIL reenable_div3[%0d]: clock_out[0]=%b tick_out[0]=%b, expected %b %b",
                 i, clock_out[0], tick_out[0], c0[5-i], t0[5-i]);
      end
      @(negedge clock_in);
    end
  endtask

  // ch0 moves to divisor 7, gets 5 queued, then reset lands at cnt=3.
  task automatic test_reset_mid();
    logic [9:0] ec = 10'b0011001100;
    logic [9:0] et = 10'b0001000100;
    wr_en = 1'b1; wr_chan = 2'd0; wr_divisor = 8'd7;
    @(negedge clock_in);
    wr_en = 1'b0;
    repeat (3) @(negedge clock_in);
    wr_en = 1'b1; wr_divisor = 8'd5;
    @(negedge clock_in);
    wr_en = 1'b0;
    tests_run++;
    if (clock_out[0] !== 1'b1) begin
      tests_failed++;
      $display("FAIL div7_cnt3: clock_out[0]=%b, expected 1", clock_out[0]);
    end
    reset = 1'b1;
    @(negedge clock_in);
    tests_run++;
    if ({clock_out, tick_out, busy} !== 6'b0) begin
      tests_failed++;
      $display("FAIL reset_mid_outputs: got %b, expected 000000", {clock_out, tick_out, busy});
    end
    @(negedge clock_in);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tests_run++;
      if (clock_out !== {2{ec[9-i]}} || tick_out !== {2{et[9-i]}}) begin
        tests_failed++;
        $display("FAIL post_reset_div4[%0d]: clock_out=%b tick_out=%b, expected %b %b",
                 i, clock_out, tick_out, {2{ec[9-i]}}, {2{et[9-i]}});
      end
      @(negedge clock_in);
    end
  endtask

  initial begin
    test_reset();
    test_write_midperiod();
    test_out_of_range();
    test_step();
    test_disable();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
